// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage hazard bus: ID operands/decode flags, E/M/W forwarding sources, and
// the forwarded operands plus stall/MD status returned to the pipeline.
interface id_hazard_ctrl_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_FWD  = 3,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 32
);
    localparam int unsigned SEL_W   = $clog2(NUM_FWD + 1);
    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned MDC_W   = $clog2(MAX_LAT + 1);

    logic                  id_valid;
    logic [4:0]            rs_addr;
    logic [4:0]            rt_addr;
    logic                  use_rs;
    logic                  use_rt;
    logic [DATA_W-1:0]     rf_a;
    logic [DATA_W-1:0]     rf_b;
    logic [NUM_FWD-1:0]    fwd_we;
    logic [5*NUM_FWD-1:0]  fwd_addr;
    logic [NUM_FWD-1:0]    fwd_ready;
    logic [DATA_W*NUM_FWD-1:0] fwd_data;
    logic                  md_start;
    logic                  md_is_div;
    logic                  md_read;
    logic                  md_cancel;

    logic [DATA_W-1:0]     ea;
    logic [DATA_W-1:0]     eb;
    logic [SEL_W-1:0]      sel_a;
    logic [SEL_W-1:0]      sel_b;
    logic                  stall;
    logic                  write_pc;
    logic                  md_busy;
    logic [MDC_W-1:0]      md_count;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_valid, rs_addr, rt_addr, use_rs, use_rt, rf_a, rf_b,
               fwd_we, fwd_addr, fwd_ready, fwd_data,
               md_start, md_is_div, md_read, md_cancel,
        input  ea, eb, sel_a, sel_b, stall, write_pc, md_busy, md_count, stall_cnt
    );

    modport slave (
        input  id_valid, rs_addr, rt_addr, use_rs, use_rt, rf_a, rf_b,
               fwd_we, fwd_addr, fwd_ready, fwd_data,
               md_start, md_is_div, md_read, md_cancel,
        output ea, eb, sel_a, sel_b, stall, write_pc, md_busy, md_count, stall_cnt
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode-stage operand forwarding and stall control: generic ready-qualified
// forwarding sources, multiply/divide busy tracking, and a saturating stall counter.
module id_hazard_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_FWD  = 3,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    id_hazard_ctrl_if.slave bus
);
    localparam int unsigned SEL_W   = $clog2(NUM_FWD + 1);
    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned MDC_W   = $clog2(MAX_LAT + 1);

    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    logic              rdy_a;
    logic              rdy_b;
    logic              haz_a;
    logic              haz_b;
    logic              md_haz;
    logic              stall;
    logic [MDC_W-1:0]  md_count;
    logic [CNT_W-1:0]  stall_cnt;

    // Walk oldest to youngest so the youngest matching source overrides.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        ea    = bus.rf_a;
        eb    = bus.rf_b;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (bus.fwd_we[i] && (bus.fwd_addr[5*i +: 5] != 5'd0)) begin
                if (bus.fwd_addr[5*i +: 5] == bus.rs_addr) begin
                    sel_a = SEL_W'(i + 1);
                    ea    = bus.fwd_data[DATA_W*i +: DATA_W];
                    rdy_a = bus.fwd_ready[i];
                end
                if (bus.fwd_addr[5*i +: 5] == bus.rt_addr) begin
                    sel_b = SEL_W'(i + 1);
                    eb    = bus.fwd_data[DATA_W*i +: DATA_W];
                    rdy_b = bus.fwd_ready[i];
                end
            end
        end
    end

    assign haz_a  = bus.use_rs && !rdy_a;
    assign haz_b  = bus.use_rt && !rdy_b;
    assign md_haz = (bus.md_read || bus.md_start) && (md_count != '0);
    // Reset forces the pipeline to run so nothing freezes while state is being cleared.
    assign stall  = !rst && bus.id_valid && (haz_a || haz_b || md_haz);

    // Remaining MD busy cycles; cancel beats a same-cycle start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_count <= '0;
        end else if (bus.md_cancel) begin
            md_count <= '0;
        end else if (bus.id_valid && bus.md_start && !stall) begin
            md_count <= bus.md_is_div ? MDC_W'(DIV_LAT) : MDC_W'(MULT_LAT);
        end else if (md_count != '0) begin
            md_count <= md_count - MDC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.ea        = ea;
    assign bus.eb        = eb;
    assign bus.sel_a     = sel_a;
    assign bus.sel_b     = sel_b;
    assign bus.stall     = stall;
    assign bus.write_pc  = !stall;
    assign bus.md_busy   = (md_count != '0);
    assign bus.md_count  = md_count;
    assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed-vector bench for id_hazard_ctrl: forwarding priority, load-use, r0,
// MD busy/cancel and asynchronous reset, with hand-computed expectations.
module tb_id_hazard_ctrl;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_FWD  = 3;
    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;
    localparam int unsigned CNT_W    = 32;

    localparam logic [31:0] RF_A = 32'hAAAA_0001;
    localparam logic [31:0] RF_B = 32'hBBBB_0002;
    localparam logic [31:0] D0   = 32'h0000_0011;
    localparam logic [31:0] D1   = 32'h0000_0022;
    localparam logic [31:0] D2   = 32'h0000_0033;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_scnt = 0;

    id_hazard_ctrl_if #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .MULT_LAT(MULT_LAT),
                        .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) bus ();

    id_hazard_ctrl #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .MULT_LAT(MULT_LAT),
                     .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        bus.id_valid  = 1'b0;
        bus.rs_addr   = 5'd0;
        bus.rt_addr   = 5'd0;
        bus.use_rs    = 1'b0;
        bus.use_rt    = 1'b0;
        bus.rf_a      = RF_A;
        bus.rf_b      = RF_B;
        bus.fwd_we    = '0;
        bus.fwd_addr  = '0;
        bus.fwd_ready = '0;
        bus.fwd_data  = {D2, D1, D0};
        bus.md_start  = 1'b0;
        bus.md_is_div = 1'b0;
        bus.md_read   = 1'b0;
        bus.md_cancel = 1'b0;
    endtask

    // Advance to just past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("rst_md_count", 64'(bus.md_count), 0);
        chk("rst_md_busy", 64'(bus.md_busy), 0);
        chk("rst_stall_cnt", 64'(bus.stall_cnt), 0);
        // Hazard inputs during reset: stall held low, selection still live.
        bus.id_valid = 1'b1; bus.use_rs = 1'b1; bus.rs_addr = 5'd5;
        bus.fwd_we = 3'b001; bus.fwd_addr = {5'd0, 5'd0, 5'd5};
        #1;
        chk("rst_stall", 64'(bus.stall), 0);
        chk("rst_write_pc", 64'(bus.write_pc), 1);
        chk("rst_sel_a", 64'(bus.sel_a), 1);
        chk("rst_ea", 64'(bus.ea), 64'(D0));
        idle();
        #20 rst = 1'b0;
        tick();

        // Forward priority: src0 and src2 both write r5.
        bus.id_valid = 1'b1; bus.use_rs = 1'b1; bus.use_rt = 1'b1;
        bus.rs_addr = 5'd5; bus.rt_addr = 5'd7;
        bus.fwd_we = 3'b111; bus.fwd_ready = 3'b111;
        bus.fwd_addr = {5'd5, 5'd7, 5'd5};
        #1;
        chk("prio_sel_a", 64'(bus.sel_a), 1);
        chk("prio_ea", 64'(bus.ea), 64'(D0));
        chk("prio_sel_b", 64'(bus.sel_b), 2);
        chk("prio_eb", 64'(bus.eb), 64'(D1));
        chk("prio_stall", 64'(bus.stall), 0);
        bus.fwd_we = 3'b100; bus.rt_addr = 5'd9;
        #1;
        chk("old_sel_a", 64'(bus.sel_a), 3);
        chk("old_ea", 64'(bus.ea), 64'(D2));
        chk("nomatch_sel_b", 64'(bus.sel_b), 0);
        chk("nomatch_eb", 64'(bus.eb), 64'(RF_B));
        idle();
        tick();

        // Load-use on rt: younger not-ready src0 blocks ready src1.
        bus.id_valid = 1'b1; bus.use_rt = 1'b1; bus.rt_addr = 5'd8;
        bus.fwd_we = 3'b011; bus.fwd_ready = 3'b010;
        bus.fwd_addr = {5'd0, 5'd8, 5'd8};
        #1;
        chk("lu_stall", 64'(bus.stall), 1);
        chk("lu_write_pc", 64'(bus.write_pc), 0);
        chk("lu_sel_b", 64'(bus.sel_b), 1);
        tick();
        exp_scnt++;
        bus.fwd_ready = 3'b011;
        #1;
        chk("lu_ready_stall", 64'(bus.stall), 0);
        chk("lu_ready_eb", 64'(bus.eb), 64'(D0));
        chk("lu_stall_cnt", 64'(bus.stall_cnt), 64'(exp_scnt));
        // Both operands hazard in one cycle: one count.
        bus.use_rs = 1'b1; bus.rs_addr = 5'd8; bus.fwd_ready = 3'b000;
        #1;
        chk("both_stall", 64'(bus.stall), 1);
        tick();
        exp_scnt++;
        chk("both_stall_cnt", 64'(bus.stall_cnt), 64'(exp_scnt));
        idle();
        tick();

        // Register 0 and unused operand never stall.
        bus.id_valid = 1'b1; bus.use_rs = 1'b1; bus.rs_addr = 5'd0;
        bus.fwd_we = 3'b001; bus.fwd_addr = {5'd0, 5'd0, 5'd0};
        #1;
        chk("r0_sel_a", 64'(bus.sel_a), 0);
        chk("r0_ea", 64'(bus.ea), 64'(RF_A));
        chk("r0_stall", 64'(bus.stall), 0);
        bus.use_rs = 1'b0; bus.rs_addr = 5'd8; bus.fwd_addr = {5'd0, 5'd0, 5'd8};
        #1;
        chk("unused_sel_a", 64'(bus.sel_a), 1);
        chk("unused_stall", 64'(bus.stall), 0);
        bus.id_valid = 1'b0; bus.use_rs = 1'b1;
        #1;
        chk("invalid_stall", 64'(bus.stall), 0);
        idle();
        tick();

        // Divide: busy for DIV_LAT cycles, mflo stalls until count reaches 0.
        bus.id_valid = 1'b1; bus.md_start = 1'b1; bus.md_is_div = 1'b1;
        #1;
        chk("div_accept_stall", 64'(bus.stall), 0);
        tick();
        bus.md_start = 1'b0; bus.md_is_div = 1'b0; bus.md_read = 1'b1;
        chk("div_busy", 64'(bus.md_busy), 1);
        for (int k = 10; k >= 1; k--) begin
            #1;
            chk($sformatf("div_count_%0d", k), 64'(bus.md_count), 64'(k));
            chk($sformatf("div_stall_%0d", k), 64'(bus.stall), 1);
            tick();
            exp_scnt++;
        end
        chk("div_done_count", 64'(bus.md_count), 0);
        chk("div_done_busy", 64'(bus.md_busy), 0);
        chk("div_done_stall", 64'(bus.stall), 0);
        chk("div_stall_cnt", 64'(bus.stall_cnt), 64'(exp_scnt));
        idle();
        tick();

        // Mult then cancel together with a start.
        bus.id_valid = 1'b1; bus.md_start = 1'b1;
        tick();
        chk("mult_count", 64'(bus.md_count), 5);
        bus.md_cancel = 1'b1;
        #1;
        chk("cancel_busy_stall", 64'(bus.stall), 1);
        tick();
        exp_scnt++;
        chk("cancel_count", 64'(bus.md_count), 0);
        bus.md_cancel = 1'b0; bus.md_start = 1'b0; bus.md_read = 1'b1;
        #1;
        chk("cancel_no_stall", 64'(bus.stall), 0);
        // Idle unit: cancel still beats a start.
        bus.md_read = 1'b0; bus.md_start = 1'b1; bus.md_cancel = 1'b1;
        tick();
        chk("cancel_idle_count", 64'(bus.md_count), 0);
        chk("cancel_stall_cnt", 64'(bus.stall_cnt), 64'(exp_scnt));
        idle();
        tick();

        // Asynchronous reset mid-operation.
        bus.id_valid = 1'b1; bus.md_start = 1'b1; bus.md_is_div = 1'b1;
        tick();
        idle();
        tick();
        tick();
        tick();
        chk("pre_rst_count", 64'(bus.md_count), 7);
        bus.id_valid = 1'b1; bus.md_read = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 64'(bus.md_count), 0);
        chk("arst_busy", 64'(bus.md_busy), 0);
        chk("arst_stall_cnt", 64'(bus.stall_cnt), 0);
        chk("arst_stall", 64'(bus.stall), 0);
        chk("arst_write_pc", 64'(bus.write_pc), 1);
        #2 rst = 1'b0;
        idle();
        tick();
        bus.id_valid = 1'b1; bus.md_start = 1'b1;
        tick();
        chk("post_rst_count", 64'(bus.md_count), 5);
        bus.md_start = 1'b0; bus.md_read = 1'b1;
        #1;
        chk("post_rst_stall", 64'(bus.stall), 1);
        tick();
        chk("post_rst_stall_cnt", 64'(bus.stall_cnt), 1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
